// File: rtl/prbs_checker.sv
// Purpose    : PRBS7 (x^7+x^6+1) receive checker with hunt/verify/lock FSM and saturating error counter.
// Latency    : locked and err_pulse are registered and change one cycle after the qualifying bit.
// Backpressure: none; din_valid low freezes all state and keeps err_pulse low.
//
// Ports: clk, rst_n (async active-low), din_valid/din (serial bit under test),
//        err_clr (sync clear of err_count), locked, err_pulse, err_count[ERR_W-1:0].
// Build option: define PRBS_CHECKER_INVERT_EN to check an inverted PRBS7 stream.
module prbs_checker #(
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]    state;
    logic [6:0]    lfsr;
    logic [2:0]    bit_cnt;
    logic [MW-1:0] match_cnt;
    logic [LW-1:0] miss_cnt;

    logic din_i;
    logic pred;
    logic mismatch;
    logic err_evt;

`ifdef PRBS_CHECKER_INVERT_EN
    assign din_i = ~din;
`else
    assign din_i = din;
`endif

    assign pred     = lfsr[6] ^ lfsr[5];
    assign mismatch = din_i ^ pred;
    // Only mismatches seen while locked are real bit errors; hunting/verifying ones are not counted.
    assign err_evt  = din_valid && (state == LOCKED) && mismatch;

    // Decoded from the state flop so reset drops it without waiting for an edge.
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            lfsr      <= 7'h00;
            bit_cnt   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err_evt;

            // A clear coinciding with an error keeps that error.
            if (err_clr) begin
                err_count <= err_evt ? ERR_W'(1) : '0;
            end else if (err_evt && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            if (din_valid) begin
                case (state)
                    HUNT: begin
                        // Seed the predictor straight from the line.
                        lfsr <= {lfsr[5:0], din_i};
                        if (bit_cnt == 3'd6) begin
                            bit_cnt <= '0;
                            state   <= VERIFY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        lfsr <= {lfsr[5:0], din_i};
                        if (!mismatch) begin
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                match_cnt <= '0;
                                state     <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so line errors do not corrupt the reference.
                        lfsr <= {lfsr[5:0], pred};
                        if (mismatch) begin
                            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                                miss_cnt  <= '0;
                                bit_cnt   <= '0;
                                match_cnt <= '0;
                                state     <= HUNT;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
